rf_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 64-bit integer register file. It shares the register file's single write port (`rd`, `rd_in`, `rd_we`) between up to four write-back sources using a valid/ready handshake and round-robin priority. It also keeps a 32-entry busy map of destination registers with issued but not yet written results, so that issue logic can detect RAW hazards on `rs1`/`rs2`. It sits between the execution/load/CSR units and the register file inside `soc`.

---
 rtl/rf_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the integer register file's single write port between NREQ
//   write-back sources, using round-robin priority and a valid/ready
//   handshake. It also keeps a 32-entry busy map of destination
//   registers that have been issued but not yet written back, so issue
//   logic can detect RAW hazards.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active low
//   req_valid[NREQ]     requester i has a write pending
//   req_ready[NREQ]     one-hot grant (combinational)
//   req_rd[5*NREQ]      destination register of requester i, bits [5i+4:5i]
//   req_data[XLEN*NREQ] write data of requester i
//   wb_rd/wb_data/wb_we register file write port (registered)
//   issue_valid/issue_rd  an instruction with a destination is issued
//   chk_rs1/chk_rs2     source registers to check for hazards
//   rs1_busy/rs2_busy   hazard flags (combinational)
//   busy_map[32]        scoreboard bits (registered), bit 0 always 0
module rf_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 wb_we,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          busy_map
);

  // Pointer width sized so that indexing NREQ-wide vectors is exact.
  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            hs;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [31:0]     busy_nxt;
  int              arb_idx;

  // Round-robin search starting at ptr, wrapping at NREQ.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    hs      = 1'b0;
    arb_idx = 0;
    for (int off = 0; off < NREQ; off++) begin
      arb_idx = int'(ptr) + off;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!hs && req_valid[arb_idx[PW-1:0]]) begin
        hs                  = 1'b1;
        gnt[arb_idx[PW-1:0]] = 1'b1;
        gnt_idx             = arb_idx[PW-1:0];
      end
    end
  end

  // Grants are suppressed while reset is held so no requester sees a
  // handshake that the registers will not record.
  assign req_ready = gnt & {NREQ{rst}};

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    if (gnt_idx == PW'(NREQ - 1)) ptr_nxt = '0;
    else                          ptr_nxt = gnt_idx + PW'(1);
  end

  // Set is applied after clear: a same-edge issue to the register being
  // written back means a newer producer is already in flight.
  always_comb begin
    busy_nxt = busy_map;
    if (hs) busy_nxt[sel_rd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      busy_map <= '0;
    end else begin
      wb_we    <= hs && (sel_rd != 5'd0);
      busy_map <= busy_nxt;
      if (hs) begin
        wb_rd   <= sel_rd;
        wb_data <= sel_data;
        ptr     <= ptr_nxt;
      end
    end
  end

  // The wb_* term covers the cycle after the busy bit clears but before
  // the register file has captured the value.
  assign rs1_busy = (chk_rs1 != 5'd0) &&
                    (busy_map[chk_rs1] || (wb_we && (wb_rd == chk_rs1)));
  assign rs2_busy = (chk_rs2 != 5'd0) &&
                    (busy_map[chk_rs2] || (wb_we && (wb_rd == chk_rs2)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int XLEN = 64;
  localparam int NREQ = 3;
  localparam int NV   = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_rd;
  logic [XLEN*NREQ-1:0] req_data;
  logic [4:0]           wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 wb_we;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic [4:0]           chk_rs1;
  logic [4:0]           chk_rs2;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [31:0]          busy_map;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_map(busy_map)
  );

  // Register file model fed by the write port.
  logic [XLEN-1:0] rf [32];
  always @(posedge clk) if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic [2:0]  ready;
    logic        b1, b2;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] busy;
  } vec_t;

  vec_t vt [NV];

  function automatic vec_t mkv(logic [2:0] valid, logic [4:0] rd0, logic [4:0] rd1,
                               logic [4:0] rd2, logic iv, logic [4:0] ird,
                               logic [4:0] rs1, logic [4:0] rs2, logic [2:0] ready,
                               logic b1, logic b2, logic we, logic [4:0] wrd,
                               logic [31:0] busy);
    vec_t v;
    v.valid = valid; v.rd0 = rd0; v.rd1 = rd1; v.rd2 = rd2;
    v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
    v.ready = ready; v.b1 = b1; v.b2 = b2; v.we = we; v.wrd = wrd; v.busy = busy;
    return v;
  endfunction

  function automatic logic [63:0] mk_data(int i, logic [4:0] rd);
    return 64'hC0DE_0000_0000_0000 | (64'(i) << 32) | 64'(rd);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_reqs(logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2);
    req_valid = v;
    req_rd    = {r2, r1, r0};
    req_data  = {mk_data(2, r2), mk_data(1, r1), mk_data(0, r0)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [XLEN-1:0] exp_data;
    logic [4:0]      r [3];

    //          valid   rd0 rd1 rd2 iv ird rs1 rs2 ready  b1 b2 we wrd busy
    vt[0]  = mkv(3'b000, 0, 0, 0, 1, 3, 3, 0, 3'b000, 0, 0, 0, 0, 32'h0000_0008);
    vt[1]  = mkv(3'b000, 0, 0, 0, 1, 4, 3, 4, 3'b000, 1, 0, 0, 0, 32'h0000_0018);
    vt[2]  = mkv(3'b111, 3, 4, 6, 0, 0, 3, 4, 3'b001, 1, 1, 1, 3, 32'h0000_0010);
    vt[3]  = mkv(3'b111, 1, 4, 6, 0, 0, 3, 4, 3'b010, 1, 1, 1, 4, 32'h0000_0000);
    vt[4]  = mkv(3'b111, 1, 5, 6, 0, 0, 3, 4, 3'b100, 0, 1, 1, 6, 32'h0000_0000);
    vt[5]  = mkv(3'b111, 1, 5, 2, 0, 0, 6, 4, 3'b001, 1, 0, 1, 1, 32'h0000_0000);
    vt[6]  = mkv(3'b101, 0, 0, 2, 0, 0, 1, 0, 3'b100, 1, 0, 1, 2, 32'h0000_0000);
    vt[7]  = mkv(3'b101, 0, 0, 7, 0, 0, 2, 1, 3'b001, 1, 0, 0, 0, 32'h0000_0000);
    vt[8]  = mkv(3'b101, 8, 0, 7, 0, 0, 0, 2, 3'b100, 0, 0, 1, 7, 32'h0000_0000);
    vt[9]  = mkv(3'b000, 0, 0, 0, 1, 0, 7, 8, 3'b000, 1, 0, 0, 7, 32'h0000_0000);
    vt[10] = mkv(3'b010, 0, 9, 0, 1, 9, 7, 9, 3'b010, 0, 0, 1, 9, 32'h0000_0200);
    vt[11] = mkv(3'b010, 0, 9, 0, 0, 0, 9, 0, 3'b010, 1, 0, 1, 9, 32'h0000_0000);
    vt[12] = mkv(3'b000, 0, 0, 0, 0, 0, 9, 0, 3'b000, 1, 0, 0, 9, 32'h0000_0000);
    vt[13] = mkv(3'b000, 0, 0, 0, 0, 0, 9, 0, 3'b000, 0, 0, 0, 9, 32'h0000_0000);

    rst = 1'b0;
    set_reqs(3'b000, 0, 0, 0);
    issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    repeat (2) step();
    set_reqs(3'b111, 1, 2, 3);
    #1;
    chk("rst ready", 64'(req_ready), 64'(3'b000));
    chk("rst we",    64'(wb_we), 64'(1'b0));
    chk("rst rd",    64'(wb_rd), 64'(5'd0));
    chk("rst data",  wb_data, 64'h0);
    chk("rst busy",  64'(busy_map), 64'h0);
    set_reqs(3'b000, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    step();

    exp_data = '0;
    for (int k = 0; k < NV; k++) begin
      set_reqs(vt[k].valid, vt[k].rd0, vt[k].rd1, vt[k].rd2);
      issue_valid = vt[k].iv; issue_rd = vt[k].ird;
      chk_rs1 = vt[k].rs1; chk_rs2 = vt[k].rs2;
      #1;
      chk($sformatf("v%0d ready", k), 64'(req_ready), 64'(vt[k].ready));
      chk($sformatf("v%0d rs1_busy", k), 64'(rs1_busy), 64'(vt[k].b1));
      chk($sformatf("v%0d rs2_busy", k), 64'(rs2_busy), 64'(vt[k].b2));
      r[0] = vt[k].rd0; r[1] = vt[k].rd1; r[2] = vt[k].rd2;
      for (int i = 0; i < 3; i++) if (vt[k].ready[i]) exp_data = mk_data(i, r[i]);
      step();
      chk($sformatf("v%0d wb_we", k), 64'(wb_we), 64'(vt[k].we));
      chk($sformatf("v%0d wb_rd", k), 64'(wb_rd), 64'(vt[k].wrd));
      chk($sformatf("v%0d wb_data", k), wb_data, exp_data);
      chk($sformatf("v%0d busy_map", k), 64'(busy_map), 64'(vt[k].busy));
    end

    // Reset asserted while a write is pending and busy_map = 0x6.
    set_reqs(3'b000, 0, 0, 0);
    issue_valid = 1'b1; issue_rd = 5'd1; step();
    issue_rd = 5'd2; step();
    issue_valid = 1'b0;
    chk("pre-rst busy", 64'(busy_map), 64'h6);
    set_reqs(3'b001, 5, 0, 0);
    step();
    chk("pre-rst we", 64'(wb_we), 64'(1'b1));
    chk("pre-rst busy2", 64'(busy_map), 64'h6);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst we",    64'(wb_we), 64'(1'b0));
    chk("async rst rd",    64'(wb_rd), 64'(5'd0));
    chk("async rst data",  wb_data, 64'h0);
    chk("async rst busy",  64'(busy_map), 64'h0);
    chk("async rst ready", 64'(req_ready), 64'(3'b000));
    set_reqs(3'b000, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    step(); step();
    chk("post-rst we", 64'(wb_we), 64'(1'b0));

    // Single write from requester 1, then read back through the model.
    set_reqs(3'b010, 0, 5, 0);
    req_data[XLEN +: XLEN] = 64'h1234_5678_9ABC_DEF0;
    chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    #1;
    chk("single ready", 64'(req_ready), 64'(3'b010));
    step();
    set_reqs(3'b000, 0, 0, 0);
    #1;
    chk("single wb_rd", 64'(wb_rd), 64'(5'd5));
    chk("single wb_data", wb_data, 64'h1234_5678_9ABC_DEF0);
    chk("single wb_we", 64'(wb_we), 64'(1'b1));
    chk("single rs1 window", 64'(rs1_busy), 64'(1'b1));
    step();
    chk("single rf read", rf[5], 64'h1234_5678_9ABC_DEF0);
    chk("single rs1 clear", 64'(rs1_busy), 64'(1'b0));

    // Round robin from ptr=0 with all valid, then with requester 1 dropped.
    rst = 1'b0; #1;
    @(negedge clk) rst = 1'b1;
    step();
    set_reqs(3'b111, 1, 2, 3);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr all %0d", c), 64'(req_ready), 64'(1 << (c % 3)));
      step();
    end
    set_reqs(3'b101, 1, 0, 3);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr drop1 %0d", c), 64'(req_ready), 64'((c % 2 == 0) ? 3'b001 : 3'b100));
      step();
    end
    set_reqs(3'b000, 0, 0, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
